triangle_area_stream: RTL and testbench

// - Streaming, back-pressurable successor to the fixed 5-cycle triangle area unit.
// - Sits between vertex transform and the rasteriser triangle setup.
// - Computes doubled signed screen-space area (OpenGL 4.6 sec.14.6.1; (0,0) top-left, CCW => positive).
// - Outputs magnitude, sign and degenerate flag, with a passthrough tag.
// - Adds valid/ready flow control, width parametrisation, an accepted-triangle counter and optional face culling.

---
 rtl/triangle_area_stream.sv | 146 ++++++++++++++
 tb/tb_triangle_area_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_area_stream.sv
// Streaming doubled signed triangle area, 5-stage valid/ready pipe.
// Optional face culling at the last stage: define TRIANGLE_AREA_CULL_EN.
module triangle_area_stream #(
  parameter int COORD_WIDTH = 17,
  parameter int TAG_WIDTH   = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [2:0][1:0][COORD_WIDTH-1:0]    vertices_in,
  input  logic [TAG_WIDTH-1:0]                tag_in,
  input  logic [1:0]                          cull_mode_in,
  input  logic                                valid_in,
  output logic                                ready_out,
  output logic                                valid_out,
  input  logic                                ready_in,
  output logic [2*COORD_WIDTH-1:0]            area_out,
  output logic                                negative_out,
  output logic                                degenerate_out,
  output logic [TAG_WIDTH-1:0]                tag_out,
  output logic [COUNT_WIDTH-1:0]              tri_count_out
);

  localparam int CW = COORD_WIDTH;
  localparam int AW = 2 * COORD_WIDTH;
  localparam int DW = AW + 1;

  typedef logic [AW-1:0] prod_t;
  typedef logic [DW-1:0] diff_t;

  function automatic prod_t mul(
    input logic [CW-1:0] a,
    input logic [CW-1:0] b
  );
    return prod_t'(a) * prod_t'(b);
  endfunction

  logic v1, v2, v3, v4;
  logic a1, a2, a3, a4, a5;
  logic take;

  prod_t [5:0] p0, p1, p2;
  diff_t [2:0] d3;
  diff_t       sum, s4;
  logic [TAG_WIDTH-1:0] t1, t2, t3, t4;

  logic          neg, deg, keep;
  logic [AW-1:0] mag;

  always_comb begin
    a5 = !valid_out || ready_in;
    a4 = !v4 || a5;
    a3 = !v3 || a4;
    a2 = !v2 || a3;
    a1 = !v1 || a2;
  end

  assign ready_out = a1;
  assign take      = valid_in && a1;

  // Product order: x0y1, x1y0, x1y2, x2y1, x2y0, x0y2
  assign p0[0] = mul(vertices_in[0][0], vertices_in[1][1]);
  assign p0[1] = mul(vertices_in[1][0], vertices_in[0][1]);
  assign p0[2] = mul(vertices_in[1][0], vertices_in[2][1]);
  assign p0[3] = mul(vertices_in[2][0], vertices_in[1][1]);
  assign p0[4] = mul(vertices_in[2][0], vertices_in[0][1]);
  assign p0[5] = mul(vertices_in[0][0], vertices_in[2][1]);

  assign sum = d3[0] + d3[1] + d3[2];

  // |s| < 2^AW, so negating the low AW bits yields the exact magnitude
  assign neg = s4[AW];
  assign deg = (s4 == '0);
  assign mag = neg ? (~s4[AW-1:0] + AW'(1)) : s4[AW-1:0];

`ifdef TRIANGLE_AREA_CULL_EN
  logic [1:0] cm1, cm2, cm3, cm4;

  assign keep = !(deg || (cm4[0] && neg) || (cm4[1] && !neg));

  always_ff @(posedge clk_in) begin
    if (a1 && valid_in) cm1 <= cull_mode_in;
    if (a2 && v1)       cm2 <= cm1;
    if (a3 && v2)       cm3 <= cm2;
    if (a4 && v3)       cm4 <= cm3;
  end
`else
  logic unused_cull;

  assign keep        = 1'b1;
  assign unused_cull = ^cull_mode_in;
`endif

  always_ff @(posedge clk_in) begin
    if (a1 && valid_in) begin
      p1 <= p0;
      t1 <= tag_in;
    end
    if (a2 && v1) begin
      p2 <= p1;
      t2 <= t1;
    end
    if (a3 && v2) begin
      d3[0] <= {1'b0, p2[1]} - {1'b0, p2[0]};
      d3[1] <= {1'b0, p2[3]} - {1'b0, p2[2]};
      d3[2] <= {1'b0, p2[5]} - {1'b0, p2[4]};
      t3    <= t2;
    end
    if (a4 && v3) begin
      s4 <= sum;
      t4 <= t3;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v1             <= 1'b0;
      v2             <= 1'b0;
      v3             <= 1'b0;
      v4             <= 1'b0;
      valid_out      <= 1'b0;
      area_out       <= '0;
      negative_out   <= 1'b0;
      degenerate_out <= 1'b0;
      tag_out        <= '0;
      tri_count_out  <= '0;
    end else begin
      if (take) tri_count_out <= tri_count_out + COUNT_WIDTH'(1);
      if (a1) v1 <= valid_in;
      if (a2) v2 <= v1;
      if (a3) v3 <= v2;
      if (a4) v4 <= v3;
      // A culled triangle never occupies the output register
      if (a5) begin
        valid_out <= v4 && keep;
        if (v4 && keep) begin
          area_out       <= mag;
          negative_out   <= neg;
          degenerate_out <= deg;
          tag_out        <= t4;
        end
      end
    end
  end

endmodule

// File: tb/tb_triangle_area_stream.sv
// Scoreboard bench for triangle_area_stream.
// Honours TRIANGLE_AREA_CULL_EN when deciding which results to expect.
module tb_triangle_area_stream;

  typedef logic [2:0][1:0][16:0] vt_t;

  logic        clk;
  logic        rst_in;
  vt_t         vertices_in;
  logic [7:0]  tag_in;
  logic [1:0]  cull_mode_in;
  logic        valid_in;
  logic        ready_out;
  logic        valid_out;
  logic        ready_in;
  logic [33:0] area_out;
  logic        negative_out;
  logic        degenerate_out;
  logic [7:0]  tag_out;
  logic [31:0] tri_count_out;

  triangle_area_stream dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .vertices_in   (vertices_in),
    .tag_in        (tag_in),
    .cull_mode_in  (cull_mode_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .area_out      (area_out),
    .negative_out  (negative_out),
    .degenerate_out(degenerate_out),
    .tag_out       (tag_out),
    .tri_count_out (tri_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int cnt_exp = 0;
  logic last_acc = 1'b0;
  logic prev_stall = 1'b0;
  logic [44:0] prev_out;
  logic [43:0] q[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic vt_t mk(input int a, input int b, input int c,
                             input int d, input int e, input int f);
    vt_t v;
    v[0][0] = 17'(a); v[0][1] = 17'(b);
    v[1][0] = 17'(c); v[1][1] = 17'(d);
    v[2][0] = 17'(e); v[2][1] = 17'(f);
    return v;
  endfunction

  task automatic model(input vt_t v, input logic [7:0] t,
                       input logic [1:0] m, output logic [43:0] e,
                       output logic keep);
    longint x0, y0, x1, y1, x2, y2, s, mg;
    logic n, d;
    x0 = longint'(v[0][0]); y0 = longint'(v[0][1]);
    x1 = longint'(v[1][0]); y1 = longint'(v[1][1]);
    x2 = longint'(v[2][0]); y2 = longint'(v[2][1]);
    s = (x1*y0 - x0*y1) + (x2*y1 - x1*y2) + (x0*y2 - x2*y0);
    n = (s < 0);
    d = (s == 0);
    mg = n ? -s : s;
    e = {mg[33:0], n, d, t};
`ifdef TRIANGLE_AREA_CULL_EN
    keep = !(d || (m[0] && n) || (m[1] && !n));
`else
    keep = (m == m);
`endif
  endtask

  always @(negedge clk) begin
    logic [43:0] e;
    logic [43:0] got;
    logic k;
    last_acc = 1'b0;
    if (rst_in) begin
      q.delete();
      cnt_exp = 0;
      prev_stall = 1'b0;
    end else begin
      check("count", tri_count_out, cnt_exp);
      if (prev_stall)
        check("hold", {valid_out, area_out, negative_out,
                       degenerate_out, tag_out}, prev_out);
      if (valid_out && ready_in) begin
        out_cnt++;
        got = {area_out, negative_out, degenerate_out, tag_out};
        if (q.size() == 0) check("spurious", got, 44'h0 ^ ~got);
        else begin
          e = q.pop_front();
          check("result", got, e);
        end
      end
      if (valid_in && ready_out) begin
        last_acc = 1'b1;
        cnt_exp++;
        model(vertices_in, tag_in, cull_mode_in, e, k);
        if (k) q.push_back(e);
      end
      prev_stall = valid_out && !ready_in;
      prev_out = {valid_out, area_out, negative_out,
                  degenerate_out, tag_out};
    end
  end

  task automatic send(input vt_t v, input logic [7:0] t,
                      input logic [1:0] m);
    vertices_in  = v;
    tag_in       = t;
    cull_mode_in = m;
    valid_in     = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (last_acc) return;
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic expect5(input logic [33:0] ar, input logic n,
                         input logic d, input logic [7:0] t,
                         input logic present);
    repeat (3) begin @(posedge clk); #1; end
    check("lat_early", valid_out, 0);
    @(posedge clk); #1;
    check("lat_valid", valid_out, present);
    if (present)
      check("lat_data", {area_out, negative_out, degenerate_out, tag_out},
            {ar, n, d, t});
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0 && !valid_out) break;
      @(posedge clk); #1;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    out_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    rst_in       = 1'b1;
    valid_in     = 1'b0;
    ready_in     = 1'b1;
    vertices_in  = '0;
    tag_in       = '0;
    cull_mode_in = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst_in = 1'b0;
    check("rst_valid", valid_out, 0);
    check("rst_data", {area_out, negative_out, degenerate_out, tag_out}, 0);
    check("rst_count", tri_count_out, 0);

    // T1 sign/magnitude
    send(mk(0, 0, 4, 0, 0, 4), 8'h11, 2'd0);
    valid_in = 1'b0;
    expect5(34'd16, 1'b1, 1'b0, 8'h11, 1'b1);
    send(mk(0, 0, 0, 4, 4, 0), 8'h12, 2'd0);
    valid_in = 1'b0;
    expect5(34'd16, 1'b0, 1'b0, 8'h12, 1'b1);

    // T2 full scale
    send(mk(0, 0, 'h1FFFF, 0, 0, 'h1FFFF), 8'h21, 2'd0);
    valid_in = 1'b0;
    expect5(34'h3FFFC0001, 1'b1, 1'b0, 8'h21, 1'b1);

    // T3 degenerate
    send(mk(1, 1, 2, 2, 3, 3), 8'h31, 2'd0);
    valid_in = 1'b0;
`ifdef TRIANGLE_AREA_CULL_EN
    expect5(34'd0, 1'b0, 1'b1, 8'h31, 1'b0);
`else
    expect5(34'd0, 1'b0, 1'b1, 8'h31, 1'b1);
`endif
    drain();

    // T4 backpressure
    pulse_reset();
    fork
      begin
        for (int k = 0; k < 10; k++)
          send(mk(k, 1, k + 7, 2 * k, 3, k + 9), 8'h40 + 8'(k), 2'd0);
        valid_in = 1'b0;
      end
      begin
        for (int c = 0; c < 15; c++) begin
          ready_in = !(c >= 3 && c <= 8);
          if (c == 8) begin
            #1;
            check("full_ready", ready_out, 0);
          end
          @(posedge clk); #1;
        end
        ready_in = 1'b1;
      end
    join
    drain();
    check("t4_beats", out_cnt, 10);
    check("t4_count", tri_count_out, 10);

    // T5 culling with mode 1
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) send(mk(0, 0, 4 + k, 0, 0, 4), 8'h50 + 8'(k), 2'd1);
      else            send(mk(0, 0, 0, 4, 4 + k, 0), 8'h50 + 8'(k), 2'd1);
    end
    valid_in = 1'b0;
    drain();
`ifdef TRIANGLE_AREA_CULL_EN
    check("t5_beats", out_cnt, 3);
`else
    check("t5_beats", out_cnt, 6);
`endif
    check("t5_count", tri_count_out, 6);

    // T6 reset with triangles in flight
    for (int k = 0; k < 3; k++)
      send(mk(k + 1, 2, 9, k, 5, 8), 8'h60 + 8'(k), 2'd0);
    valid_in = 1'b0;
    pulse_reset();
    check("t6_valid", valid_out, 0);
    check("t6_count", tri_count_out, 0);
    check("t6_area", area_out, 0);
    repeat (10) begin @(posedge clk); #1; end
    check("t6_beats", out_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
